// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU datapath / loader-debug host) arbiter for a single-port memory bus.
// Round-robin tie-break with optional host burst retention (host_lock).
module mem_bus_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  input  logic              host_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {GRANT_CPU, GRANT_HOST} grant_t;

  localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

  state_t     state, state_nx;
  grant_t     grant, grant_nx, last_grant;
  logic [7:0] burst_cnt;
  logic       burst_hold;
  logic       cpu_elig, host_elig;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= GRANT_CPU;
      last_grant <= GRANT_HOST;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      if (state != ACCESS && state_nx == ACCESS)
        last_grant <= grant_nx;
    end
  end

  // Next-state and grant selection; in RESP the just-acked side is masked
  // unless it is the host holding a live burst.
  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    cpu_elig  = 1'b0;
    host_elig = 1'b0;
    case (state)
      IDLE: begin
        cpu_elig  = cpu_req;
        host_elig = host_req;
      end
      RESP: begin
        cpu_elig  = cpu_req & (grant != GRANT_CPU);
        host_elig = host_req & ((grant != GRANT_HOST) | burst_hold);
      end
      default: ;
    endcase
    case (state)
      IDLE, RESP: begin
        if (cpu_elig || host_elig) begin
          state_nx = ACCESS;
          if (host_elig && (burst_hold || !cpu_elig || last_grant == GRANT_CPU))
            grant_nx = GRANT_HOST;
          else
            grant_nx = GRANT_CPU;
        end else begin
          state_nx = IDLE;
        end
      end
      ACCESS:  state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  // Burst bookkeeping, evaluated once per ACCESS cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt  <= '0;
      burst_hold <= 1'b0;
    end else if (state == ACCESS) begin
      if (grant == GRANT_CPU) begin
        burst_cnt  <= '0;
        burst_hold <= 1'b0;
      end else if (host_lock && burst_cnt < BURST_LAST) begin
        burst_cnt  <= burst_cnt + 8'd1;
        burst_hold <= 1'b1;
      end else begin
        burst_hold <= 1'b0;
        if (!host_lock)
          burst_cnt <= '0;
      end
    end
  end

  // Read data capture on the ACCESS->RESP edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else if (state == ACCESS) begin
      if (grant == GRANT_CPU && !cpu_we)
        cpu_rdata <= mem_rdata;
      if (grant == GRANT_HOST && !host_we)
        host_rdata <= mem_rdata;
    end
  end

  // Outputs
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    cpu_ack   = 1'b0;
    host_ack  = 1'b0;
    case (state)
      ACCESS: begin
        if (grant == GRANT_HOST) begin
          mem_addr  = host_addr;
          mem_wdata = host_wdata;
          mem_we    = host_we;
          mem_re    = ~host_we;
        end else begin
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          mem_we    = cpu_we;
          mem_re    = ~cpu_we;
        end
      end
      RESP: begin
        cpu_ack  = (grant == GRANT_CPU);
        host_ack = (grant == GRANT_HOST);
      end
      default: ;
    endcase
    cpu_stall = cpu_req & ~cpu_ack;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter BURST_MAX, default 8, max consecutive locked host grants (range 2..255).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 cpu_req  input  1  datapath access request, held until cpu_ack.
REQ-008 cpu_we  input  1  1 = write, 0 = read; held with cpu_req.
REQ-009 cpu_addr  input  ADDR_W  datapath address (ALU result).
REQ-010 cpu_wdata  input  DATA_W  datapath store data.
REQ-011 cpu_rdata  output  DATA_W  registered read data, valid while cpu_ack=1.
REQ-012 cpu_ack  output  1  one-cycle completion pulse.
REQ-013 cpu_stall  output  1  freeze PC/writeback: cpu_req & ~cpu_ack.
REQ-014 host_req, host_we, host_addr, host_wdata, host_rdata, host_ack: same widths/rules as the cpu_* equivalents, for the loader/debug host.
REQ-015 host_lock  input  1  host requests bus retention for a burst.
REQ-016 mem_addr  output  ADDR_W  shared memory/IO address.
REQ-017 mem_wdata  output  DATA_W  shared write data.
REQ-018 mem_we, mem_re  output  1 each  write/read strobes.
REQ-019 mem_rdata  input  DATA_W  combinational memory read data.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS, RESP; a grant register selects CPU or HOST.
REQ-021 IDLE: if any req is high, the FSM SHALL move to ACCESS at the next edge with the grant chosen per REQ-025/026; otherwise it stays in IDLE.
REQ-022 ACCESS (exactly 1 cycle): mem_addr/mem_wdata SHALL equal the granted requester's inputs; mem_we = granted we; mem_re = ~granted we; the FSM goes to RESP.
REQ-023 On the ACCESS->RESP edge, mem_rdata SHALL be latched into the granted rdata register (reads only; writes leave rdata unchanged), and the granted ack SHALL be high for the whole RESP cycle.
REQ-024 RESP: the acked requester's req SHALL be ignored; if the other req is high, go to ACCESS granting it, else go to IDLE.
REQ-025 Tie (both reqs eligible): the winner SHALL be the requester not granted last (round-robin on last_grant), unless REQ-026 applies.
REQ-026 Burst: when a host ACCESS occurs with host_lock=1 and burst_cnt < BURST_MAX-1, burst_cnt SHALL increment, and host SHALL win the next arbitration, including from RESP (its own req is then not ignored).
REQ-027 burst_cnt SHALL clear on any CPU grant or on any host ACCESS with host_lock=0; at BURST_MAX the next tie SHALL go to CPU.
REQ-028 Outside ACCESS, mem_we and mem_re SHALL be 0 and mem_addr/mem_wdata 0.
REQ-029 Latency: req sampled in IDLE gives ack 2 cycles later; minimum 2 cycles per access; at most 1 mem strobe per 2 cycles.
REQ-030 A requester dropping req before ack SHALL NOT abort an access already in ACCESS; an ack still issues.

Reset
REQ-031 While rst_n=0, the block SHALL be asynchronously in state IDLE with last_grant=HOST (CPU wins the first tie), burst_cnt=0, both acks 0, both rdata 0, and all mem_* outputs 0.
REQ-032 Reset asserted mid-ACCESS or mid-RESP SHALL deassert mem_we/mem_re immediately and SHALL issue no ack for the aborted access.

Verification
REQ-033 CPU write addr 0x0010 data 0xBEEF, req at cycle 0 -> mem_we=1 with addr 0x0010 in cycle 1, cpu_ack in cycle 2, cpu_stall high in cycles 0-1; a subsequent host read of 0x0010 returns host_rdata=0xBEEF with host_ack.
REQ-034 Both reqs raised at cycle 0 after reset -> CPU ACCESS in cycle 1, cpu_ack in cycle 2, host ACCESS in cycle 3, host_ack in cycle 4.
REQ-035 Both reqs held continuously with host_lock=0 -> grants alternate CPU, HOST, CPU, HOST; no req waits more than one foreign access.
REQ-036 host_lock=1 with both reqs held, host granted first -> 8 consecutive host acks, then 1 CPU ack, then host resumes.
REQ-037 rst_n pulled low in a host write ACCESS cycle -> mem_we=0 in the same cycle, no host_ack, FSM in IDLE after release.
REQ-038 CPU read with cpu_req dropped during ACCESS -> cpu_ack still pulses once, cpu_rdata equals mem_rdata, FSM returns to IDLE.
